// File: rtl/dht_pkg.sv
// ============================================================================
// Package     : dht_pkg
// Description : Shared definitions for the DHT11 frame sender: FSM state
//               encoding, frame length and default framing bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dht_pkg;

    // Frame sender FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } dht_state_t;

    // Header + 5 reading bytes + footer
    localparam int         FRAME_LEN      = 7;
    localparam logic [7:0] DEFAULT_HEADER = 8'hAA;
    localparam logic [7:0] DEFAULT_FOOTER = 8'h55;

endpackage : dht_pkg

`default_nettype wire

// File: rtl/dht_frame_sender.sv
// ============================================================================
// Module      : dht_frame_sender
// Description : Frames a 40-bit DHT11 reading as HEADER, hum_int, hum_dec,
//               temp_int, temp_dec, checksum, FOOTER and hands it byte by
//               byte to the ComunicationModule (senddata/txdone handshake),
//               with a per-byte timeout and overrun detection.
//               Optional feature: define DHT_CHECKSUM_EN to reject readings
//               whose checksum does not match at capture time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dht_frame_sender
    import dht_pkg::*;
#(
    parameter logic [7:0] HEADER     = DEFAULT_HEADER,
    parameter logic [7:0] FOOTER     = DEFAULT_FOOTER,
    parameter int         TX_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] data_in,
    input  logic        data_valid,
    output logic [7:0]  txbyte,
    output logic        senddata,
    input  logic        txdone,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);

    localparam int             c_CW       = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TX_TIMEOUT - 1);
    localparam logic [2:0]     c_IDX_LAST = 3'(FRAME_LEN - 1);

    dht_state_t      r_state, w_state_nxt;
    logic [39:0]     r_data, w_data_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]      r_txbyte, w_txbyte_nxt;
    logic            r_senddata, w_senddata_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_frame_done, w_frame_done_nxt;
    logic            r_err, w_err_nxt;
    logic            w_csum_ok;

`ifdef DHT_CHECKSUM_EN
    logic [7:0] w_sum;
    assign w_sum     = data_in[39:32] + data_in[31:24] + data_in[23:16] + data_in[15:8];
    assign w_csum_ok = (w_sum == data_in[7:0]);
`else
    assign w_csum_ok = 1'b1;
`endif

    // Next-state and next-output logic; every output is registered so
    // txbyte holds its value untouched between LOAD cycles
    always_comb begin
        w_state_nxt      = r_state;
        w_data_nxt       = r_data;
        w_idx_nxt        = r_idx;
        w_cnt_nxt        = r_cnt;
        w_txbyte_nxt     = r_txbyte;
        w_senddata_nxt   = 1'b0;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;
        w_err_nxt        = 1'b0;

        // A new reading while a frame is in flight (including DONE) is dropped
        if (data_valid && (r_state != ST_IDLE)) begin
            w_err_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (data_valid) begin
                    if (w_csum_ok) begin
                        w_data_nxt  = data_in;
                        w_idx_nxt   = 3'd0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                case (r_idx)
                    3'd0:    w_txbyte_nxt = HEADER;
                    3'd1:    w_txbyte_nxt = r_data[39:32];
                    3'd2:    w_txbyte_nxt = r_data[31:24];
                    3'd3:    w_txbyte_nxt = r_data[23:16];
                    3'd4:    w_txbyte_nxt = r_data[15:8];
                    3'd5:    w_txbyte_nxt = r_data[7:0];
                    default: w_txbyte_nxt = FOOTER;
                endcase
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                w_senddata_nxt = 1'b1;
                w_cnt_nxt      = '0;
                w_state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                if (txdone) begin
                    w_state_nxt = ST_NEXT;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_NEXT: begin
                if (r_idx == c_IDX_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt   = r_idx + 3'd1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_DONE: begin
                w_frame_done_nxt = 1'b1;
                w_busy_nxt       = 1'b0;
                w_idx_nxt        = 3'd0;
                w_state_nxt      = ST_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_idx_nxt   = 3'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, byte index, timeout counter and captured reading
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_idx   <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txbyte     <= 8'h00;
            r_senddata   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_txbyte     <= w_txbyte_nxt;
            r_senddata   <= w_senddata_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign txbyte     = r_txbyte;
    assign senddata   = r_senddata;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign err        = r_err;

endmodule : dht_frame_sender

`default_nettype wire

// File: tb/tb_dht_frame_sender.sv
// ============================================================================
// Module      : tb_dht_frame_sender
// Description : Directed self-checking bench for dht_frame_sender. A model
//               of the ComunicationModule answers each senddata with a
//               txdone pulse 10 cycles later. Covers DHT_CHECKSUM_EN in
//               both builds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dht_frame_sender;

    localparam int c_TX_TIMEOUT = 20;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic [39:0] data_in    = '0;
    logic        data_valid = 1'b0;
    logic        txdone     = 1'b0;
    logic [7:0]  txbyte;
    logic        senddata;
    logic        busy;
    logic        frame_done;
    logic        err;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   dv_cyc = 0;
    logic [7:0] sent_q[$];
    int   sent_cyc_q[$];
    int   n_done = 0;
    int   n_err  = 0;
    int   last_err_cyc = 0;
    bit   resp_en = 1'b1;

    dht_frame_sender #(
        .HEADER     (8'hAA),
        .FOOTER     (8'h55),
        .TX_TIMEOUT (c_TX_TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .txbyte     (txbyte),
        .senddata   (senddata),
        .txdone     (txdone),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Record every transmitted byte and every status pulse
    always @(negedge clk) begin
        if (senddata) begin
            sent_q.push_back(txbyte);
            sent_cyc_q.push_back(cyc);
        end
        if (frame_done) n_done = n_done + 1;
        if (err) begin
            n_err        = n_err + 1;
            last_err_cyc = cyc;
        end
    end

    // ComunicationModule model: txdone 10 cycles after each senddata
    always begin
        @(negedge clk);
        if (senddata && resp_en) begin
            repeat (10) @(posedge clk);
            #1 txdone = 1'b1;
            @(posedge clk);
            #1 txdone = 1'b0;
        end
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_dv(input logic [39:0] d);
        @(posedge clk);
        #1;
        data_in    = d;
        data_valid = 1'b1;
        dv_cyc     = cyc;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int k = 0;
        while (sent_q.size() < n && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, 64'(sent_q.size() >= n), 64'd1);
    endtask

    task automatic wait_done(input int n, input string tag);
        int k = 0;
        while (n_done < n && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, 64'(n_done >= n), 64'd1);
    endtask

    task automatic check_frame(input int base, input logic [39:0] d, input string tag);
        logic [7:0]  exp_b [7];
        logic [63:0] got;
        exp_b[0] = 8'hAA;
        exp_b[1] = d[39:32];
        exp_b[2] = d[31:24];
        exp_b[3] = d[23:16];
        exp_b[4] = d[15:8];
        exp_b[5] = d[7:0];
        exp_b[6] = 8'h55;
        for (int i = 0; i < 7; i++) begin
            got = (base + i < sent_q.size()) ? 64'(sent_q[base + i]) : 64'h1FF;
            check($sformatf("%s_b%0d", tag, i), got, 64'(exp_b[i]));
        end
    endtask

    initial begin
        int b;
        int b2;
        int d0;
        int e0;
        int k;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txbyte", 64'(txbyte), 64'h00);
        check("rst_senddata", 64'(senddata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic frame
        b = sent_q.size(); d0 = n_done; e0 = n_err;
        pulse_dv(40'h3700190050);
        @(negedge clk);
        check("basic_busy_hi", 64'(busy), 64'd1);
        wait_done(d0 + 1, "basic_done_seen");
        check_frame(b, 40'h3700190050, "basic");
        check("basic_latency", 64'(sent_cyc_q[b] - dv_cyc), 64'd3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        check("basic_nbytes", 64'(sent_q.size() - b), 64'd7);
        check("basic_ndone", 64'(n_done - d0), 64'd1);
        check("basic_noerr", 64'(n_err - e0), 64'd0);
        check("basic_busy_lo", 64'(busy), 64'd0);

        // Reading with a bad checksum
        b = sent_q.size(); d0 = n_done; e0 = n_err;
        pulse_dv(40'h3700190051);
`ifdef DHT_CHECKSUM_EN
        k = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) k++;
        end
        #1;
        check("csum_err", 64'(n_err - e0), 64'd1);
        check("csum_nobytes", 64'(sent_q.size() - b), 64'd0);
        check("csum_busy_cycles", 64'(k), 64'd0);
`else
        wait_done(d0 + 1, "csum_done_seen");
        check_frame(b, 40'h3700190051, "csum");
        check("csum_noerr", 64'(n_err - e0), 64'd0);
`endif
        repeat (3) @(posedge clk);

        // Overrun during byte 3
        b = sent_q.size(); d0 = n_done; e0 = n_err;
        pulse_dv(40'h3700190050);
        wait_bytes(b + 4, "ovr_byte3_seen");
        pulse_dv(40'h1122334466);
        wait_done(d0 + 1, "ovr_done_seen");
        check_frame(b, 40'h3700190050, "ovr");
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        check("ovr_err", 64'(n_err - e0), 64'd1);
        check("ovr_nbytes", 64'(sent_q.size() - b), 64'd7);
        check("ovr_ndone", 64'(n_done - d0), 64'd1);
        check("ovr_busy_lo", 64'(busy), 64'd0);

        // Timeout: txdone withheld after the first senddata
        resp_en = 1'b0;
        b = sent_q.size(); d0 = n_done; e0 = n_err;
        pulse_dv(40'h3700190050);
        k = 0;
        while (n_err == e0 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("tmo_err_seen", 64'(n_err - e0), 64'd1);
        check("tmo_delay", 64'((sent_q.size() > b) ? (last_err_cyc - sent_cyc_q[b]) : -1), 64'd20);
        check("tmo_busy_lo", 64'(busy), 64'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        check("tmo_nbytes", 64'(sent_q.size() - b), 64'd1);
        check("tmo_nodone", 64'(n_done - d0), 64'd0);
        resp_en = 1'b1;

        // Reset during the wait for byte 4
        b = sent_q.size(); d0 = n_done; e0 = n_err;
        pulse_dv(40'h3700190050);
        wait_bytes(b + 5, "rstmid_byte4_seen");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_outs", 64'({txbyte, senddata, busy, frame_done, err}), 64'd0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        #1;
        check("rstmid_nbytes", 64'(sent_q.size() - b), 64'd5);
        check("rstmid_busy_lo", 64'(busy), 64'd0);
        check("rstmid_nodone", 64'(n_done - d0), 64'd0);
        b2 = sent_q.size();
        pulse_dv(40'h3700190050);
        wait_done(d0 + 1, "rstmid_fresh_done");
        check_frame(b2, 40'h3700190050, "rstmid_fresh");

        // Back-to-back readings
        repeat (3) @(posedge clk);
        b = sent_q.size(); d0 = n_done; e0 = n_err;
        pulse_dv(40'h3700190050);
        wait_done(d0 + 1, "b2b_done1");
        pulse_dv(40'h11223344AA);
        wait_done(d0 + 2, "b2b_done2");
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        check("b2b_nbytes", 64'(sent_q.size() - b), 64'd14);
        check("b2b_ndone", 64'(n_done - d0), 64'd2);
        check("b2b_noerr", 64'(n_err - e0), 64'd0);
        check_frame(b, 40'h3700190050, "b2b_f1");
        check_frame(b + 7, 40'h11223344AA, "b2b_f2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dht_frame_sender

`default_nettype wire

// File: doc/dht_frame_sender.md
DHT_FRAME_SENDER -- requirements
Module: dht_frame_sender

Interface
REQ-001 Parameter HEADER, 8'hAA, first byte of every frame.
REQ-002 Parameter FOOTER, 8'h55, last byte of every frame.
REQ-003 Parameter TX_TIMEOUT, 100000, max clk cycles to wait for txdone per byte.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 data_in  input  40  DHT11 reading: [39:32] hum_int, [31:24] hum_dec, [23:16] temp_int, [15:8] temp_dec, [7:0] checksum.
REQ-007 data_valid  input  1  one-cycle strobe; data_in valid in the same cycle.
REQ-008 txbyte  output  8  byte presented to ComunicationModule.
REQ-009 senddata  output  1  one-cycle request to ComunicationModule to transmit txbyte.
REQ-010 txdone  input  1  one-cycle pulse from ComunicationModule when the current byte has finished.
REQ-011 busy  output  1  high from frame accept until frame end or abort.
REQ-012 frame_done  output  1  one-cycle pulse after the FOOTER byte's txdone.
REQ-013 err  output  1  one-cycle pulse on checksum reject, overrun or timeout.

Function
REQ-014 Frame order SHALL be HEADER, hum_int, hum_dec, temp_int, temp_dec, checksum, FOOTER, 7 bytes in total.
REQ-015 States: IDLE, LOAD, SEND, WAIT, NEXT, DONE.
REQ-016 IDLE: data_valid=1 -> capture data_in into a 40-bit register, busy=1 next cycle, -> LOAD.
REQ-017 LOAD: drive txbyte from the 3-bit byte index (0..6), -> SEND.
REQ-018 SEND: senddata=1 for exactly one cycle, clear the timeout counter, -> WAIT.
REQ-019 WAIT: txdone=1 -> NEXT; the timeout counter reaching TX_TIMEOUT-1 -> err pulse, busy=0, -> IDLE (abort; no frame_done).
REQ-020 NEXT: index==6 -> DONE; otherwise index+1, -> LOAD.
REQ-021 DONE: frame_done=1 for one cycle, busy=0, index=0, -> IDLE.
REQ-022 txbyte SHALL stay stable from SEND until txdone is seen.
REQ-023 data_valid while busy=1 SHALL be ignored, with an err pulse (overrun); the frame in flight is unaffected.
REQ-024 txdone outside WAIT SHALL be ignored.
REQ-025 Latency from data_valid to the first senddata SHALL be exactly 3 cycles (IDLE->LOAD->SEND).
REQ-026 A data_valid in the same cycle as the DONE->IDLE transition SHALL be an overrun; acceptance resumes the next cycle.

Reset
REQ-027 rst=1 SHALL force IDLE, index=0, and set txbyte=0, senddata=0, busy=0, frame_done=0, err=0 on the next edge, including mid-frame.
REQ-028 A txdone arriving after a mid-frame reset SHALL have no effect.

Configuration
REQ-029 Macro DHT_CHECKSUM_EN defined: on capture, (hum_int+hum_dec+temp_int+temp_dec) mod 256 != checksum -> err pulse, stay IDLE, nothing sent.
REQ-030 Macro DHT_CHECKSUM_EN undefined: every accepted reading is framed and sent regardless of checksum.

Structure
REQ-031 Shared package dht_pkg SHALL hold the state encoding, FRAME_LEN=7 and the default HEADER/FOOTER constants.
REQ-032 Single module with no sub-modules; the byte-select mux and the timeout counter stay inline.

Verification
REQ-033 data_in=40'h3700190050, data_valid pulse, txdone returned 10 cycles after each senddata -> txbyte sequence AA,37,00,19,00,50,55, then one frame_done pulse.
REQ-034 DHT_CHECKSUM_EN defined, data_in=40'h3700190051 -> err pulse, senddata never asserted, busy stays 0.
REQ-035 Second data_valid (40'h1122334466) during byte 3 -> err pulse, first frame completes unchanged, then IDLE.
REQ-036 txdone withheld after the first senddata, TX_TIMEOUT=20 -> err pulse 20 cycles later, busy=0, no frame_done.
REQ-037 rst asserted for 1 cycle during WAIT of byte 4 -> all outputs 0 next cycle; a later txdone is ignored; a new data_valid starts a fresh frame with AA.
REQ-038 Back-to-back readings, the second data_valid 1 cycle after frame_done -> 14 bytes sent, 2 frame_done pulses, no err.
